// File: rtl/led_fade_pwm_pkg.sv
// Shared constants, level type and saturating step helper for the LED fade/PWM block.
// Pure definitions: no latency, no backpressure.
package led_pkg;

  localparam int N_LED     = 8;
  localparam int PWM_MAX   = 254;
  localparam int LEVEL_MAX = 255;

  typedef logic [7:0] level_t;

  // Done in 9 bits so overflow/underflow shows up in bit 8 and clamps instead of wrapping.
  function automatic level_t sat_step(input level_t lvl, input logic up,
                                      input level_t rise, input level_t fall);
    logic [8:0] acc;
    if (up) begin
      acc = {1'b0, lvl} + {1'b0, rise};
      return acc[8] ? level_t'(LEVEL_MAX) : acc[7:0];
    end
    acc = {1'b0, lvl} - {1'b0, fall};
    return acc[8] ? '0 : acc[7:0];
  endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern-in / LED-out bundle between the pattern generator, this block and the pins.
// Plain wires: no latency, no backpressure.
interface led_fade_pwm_if;
  import led_pkg::*;

  logic [N_LED-1:0] pattern_in;
  logic [N_LED-1:0] led_out;
  logic             fade_tick;

  modport master (output pattern_in, input led_out, input fade_tick);
  modport slave  (input pattern_in, output led_out, output fade_tick);

endinterface

// File: rtl/led_fade_pwm_channel.sv
// One LED: brightness level with saturating rise/fall on fade_tick, registered PWM compare.
// Latency: level updates on the tick edge, led 1 cycle after level/pwm_cnt; no backpressure.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter level_t RISE_STEP = 8'd255,
  parameter level_t FALL_STEP = 8'd8
) (
  input  logic   clk_50M,
  input  logic   reset,
  input  logic   fade_tick,
  input  logic   target_bit,
  input  level_t pwm_cnt,
  output logic   led
);

  level_t level;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (fade_tick) begin
        level <= sat_step(level, target_bit, RISE_STEP, FALL_STEP);
      end
      // pwm_cnt never exceeds 254, so level 255 stays on and level 0 stays off.
      led <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// Syncs the async LED pattern and drives each LED with PWM that rises/fades per fade tick.
// Latency: pattern->target 3 edges, target->level at next tick, led_out +1 cycle; no backpressure.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned FADE_PERIODS = 196,
  parameter int unsigned RISE_STEP    = 255,
  parameter int unsigned FALL_STEP    = 8
) (
  input  logic           clk_50M,
  input  logic           reset,
  led_fade_pwm_if.slave  bus
);

  localparam logic [9:0] PER_LAST = 10'(FADE_PERIODS - 1);

  logic [N_LED-1:0] sync1, sync2, sync3;
  logic [N_LED-1:0] target;
  level_t           pwm_cnt;
  logic [9:0]       per_cnt;
  logic             tick;
  logic [N_LED-1:0] led_bits;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      target  <= '0;
      pwm_cnt <= '0;
      per_cnt <= '0;
    end else begin
      sync1 <= bus.pattern_in;
      sync2 <= sync1;
      sync3 <= sync2;
      // Two matching samples in a row: rejects single-cycle glitches and multi-bit skew.
      if (sync2 == sync3) begin
        target <= sync2;
      end
      if (pwm_cnt == level_t'(PWM_MAX)) begin
        pwm_cnt <= '0;
        per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 10'd1;
      end else begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

  // Decoded from registered counters; levels sample it on the period-wrap edge.
  assign tick = (pwm_cnt == level_t'(PWM_MAX)) && (per_cnt == PER_LAST);

  for (genvar i = 0; i < N_LED; i++) begin : gen_ch
    led_pwm_channel #(
      .RISE_STEP (level_t'(RISE_STEP)),
      .FALL_STEP (level_t'(FALL_STEP))
    ) u_ch (
      .clk_50M    (clk_50M),
      .reset      (reset),
      .fade_tick  (tick),
      .target_bit (target[i]),
      .pwm_cnt    (pwm_cnt),
      .led        (led_bits[i])
    );
  end

  assign bus.led_out   = led_bits;
  assign bus.fade_tick = tick;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: directed tables plus random pattern/reset traffic against a model.
module tb_led_fade_pwm;

  localparam int FP       = 2;
  localparam int RISE_A   = 255;
  localparam int FALL_A   = 64;
  localparam int TICK_LEN = 255 * FP;

  logic clk_50M = 1'b0;
  logic reset;

  led_fade_pwm_if bus_a();
  led_fade_pwm_if bus_s();

  led_fade_pwm #(.FADE_PERIODS(FP), .RISE_STEP(RISE_A), .FALL_STEP(FALL_A)) dut_a (
    .clk_50M (clk_50M),
    .reset   (reset),
    .bus     (bus_a)
  );

  led_fade_pwm #(.FADE_PERIODS(FP), .RISE_STEP(100), .FALL_STEP(64)) dut_s (
    .clk_50M (clk_50M),
    .reset   (reset),
    .bus     (bus_s)
  );

  always #5 clk_50M = ~clk_50M;

  int n_checks = 0;
  int n_fail   = 0;
  int hi[8];
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic tick_of(input bit sel);
    return sel ? bus_s.fade_tick : bus_a.fade_tick;
  endfunction

  function automatic logic [7:0] led_of(input bit sel);
    return sel ? bus_s.led_out : bus_a.led_out;
  endfunction

  // Returns at the negedge just before the tick (level-update) edge.
  task automatic wait_tick(input bit sel, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk_50M);
      if (tick_of(sel) === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no fade_tick within 1200 cycles", name);
    end
  endtask

  // High-time of each LED over the full period following the tick edge.
  task automatic measure(input bit sel);
    logic [7:0] l;
    for (int i = 0; i < 8; i++) hi[i] = 0;
    @(negedge clk_50M);
    repeat (255) begin
      @(negedge clk_50M);
      l = led_of(sel);
      for (int i = 0; i < 8; i++) hi[i] += int'(l[i]);
    end
  endtask

  // Cycles from reset release to the first level-update edge.
  task automatic first_tick(input string name);
    int n = 0;
    bit found = 1'b0;
    while (n < 1200 && !found) begin
      @(negedge clk_50M);
      n++;
      if (bus_a.fade_tick === 1'b1) found = 1'b1;
    end
    check(name, n + 1, 510);
  endtask

  // Reference model: levels, sampled pattern history and elapsed edges since reset.
  int         m_age = 0;
  bit [7:0]   m_tgt = 0;
  bit [7:0]   m_smp [3];
  int         m_lvl [8];
  bit [7:0]   led_exp = 0;
  bit         tick_exp = 0;

  always @(posedge clk_50M) begin
    if (reset) begin
      m_age = 0;
      m_tgt = 0;
      for (int i = 0; i < 3; i++) m_smp[i] = 0;
      for (int i = 0; i < 8; i++) m_lvl[i] = 0;
      led_exp = 0;
    end else begin
      for (int i = 0; i < 8; i++) led_exp[i] = (m_lvl[i] > (m_age % 255));
      if ((m_age % TICK_LEN) == TICK_LEN - 1) begin
        for (int i = 0; i < 8; i++) begin
          if (m_tgt[i]) m_lvl[i] = (m_lvl[i] + RISE_A > 255) ? 255 : m_lvl[i] + RISE_A;
          else          m_lvl[i] = (m_lvl[i] - FALL_A < 0)   ? 0   : m_lvl[i] - FALL_A;
        end
      end
      // Pattern adopted once the two previous samples agree.
      if (m_smp[1] == m_smp[2]) m_tgt = m_smp[1];
      m_smp[2] = m_smp[1];
      m_smp[1] = m_smp[0];
      m_smp[0] = bus_a.pattern_in;
      m_age++;
    end
    tick_exp = (m_age % TICK_LEN) == TICK_LEN - 1;
  end

  always @(negedge clk_50M) begin
    if (cmp_en) begin
      check("random led_out", bus_a.led_out, led_exp);
      check("random fade_tick", bus_a.fade_tick, tick_exp);
    end
  end

  typedef struct {
    logic [7:0]      pat;
    logic [7:0][7:0] lvl;
  } vec_t;

  vec_t vecs[9];
  int   sat_exp[4];

  initial begin
    vecs[0] = '{8'h01, {8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd255}};
    vecs[1] = '{8'h00, {8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd191}};
    vecs[2] = '{8'h00, {8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd127}};
    vecs[3] = '{8'h00, {8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd63}};
    vecs[4] = '{8'h00, {8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0}};
    vecs[5] = '{8'hA5, {8'd255, 8'd0,   8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   8'd255}};
    vecs[6] = '{8'h5A, {8'd191, 8'd255, 8'd191, 8'd255, 8'd255, 8'd191, 8'd255, 8'd191}};
    vecs[7] = '{8'hFF, {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}};
    vecs[8] = '{8'h0F, {8'd191, 8'd191, 8'd191, 8'd191, 8'd255, 8'd255, 8'd255, 8'd255}};
    sat_exp = '{100, 200, 255, 255};

    reset = 1'b1;
    bus_a.pattern_in = 8'h00;
    bus_s.pattern_in = 8'h00;

    // Reset state and first tick position.
    repeat (3) @(negedge clk_50M);
    check("reset led_out", bus_a.led_out, 8'h00);
    check("reset fade_tick", bus_a.fade_tick, 1'b0);
    check("reset led_out sat", bus_s.led_out, 8'h00);
    reset = 1'b0;
    first_tick("first tick after reset");

    // Synchronizer latency: change seen at edge 1 lands in target at edge 4.
    begin
      int n = 0;
      bit found = 1'b0;
      bus_a.pattern_in = 8'h01;
      while (n < 10 && !found) begin
        @(negedge clk_50M);
        n++;
        if (dut_a.target === 8'h01) found = 1'b1;
      end
      check("target latency", n, 4);
    end

    // Rise / fade / multi-LED table.
    for (int v = 0; v < 9; v++) begin
      bus_a.pattern_in = vecs[v].pat;
      repeat (4) @(negedge clk_50M);
      wait_tick(1'b0, $sformatf("vec%0d tick", v));
      measure(1'b0);
      for (int i = 0; i < 8; i++)
        check($sformatf("vec%0d led%0d hightime", v, i), hi[i], vecs[v].lvl[i]);
    end

    // Single-cycle glitch never reaches target or the LEDs.
    reset = 1'b1;
    bus_a.pattern_in = 8'h00;
    repeat (2) @(negedge clk_50M);
    reset = 1'b0;
    repeat (3) @(negedge clk_50M);
    bus_a.pattern_in = 8'hFF;
    @(negedge clk_50M);
    bus_a.pattern_in = 8'h00;
    begin
      logic [7:0] seen = 8'h00;
      repeat (6) begin
        @(negedge clk_50M);
        seen |= dut_a.target;
      end
      check("glitch target", seen, 8'h00);
    end
    wait_tick(1'b0, "glitch tick");
    measure(1'b0);
    check("glitch led hightime", hi[0] + hi[1] + hi[2] + hi[3] + hi[4] + hi[5] + hi[6] + hi[7], 0);

    // Two stable samples are enough to be adopted.
    bus_a.pattern_in = 8'hFF;
    repeat (2) @(negedge clk_50M);
    bus_a.pattern_in = 8'h00;
    begin
      bit hit = 1'b0;
      repeat (6) begin
        @(negedge clk_50M);
        if (dut_a.target === 8'hFF) hit = 1'b1;
      end
      check("two-cycle pulse adopted", hit, 1'b1);
    end

    // Reset mid-fade at level 127; tick edge with a fresh target change uses the old one.
    reset = 1'b1;
    repeat (2) @(negedge clk_50M);
    reset = 1'b0;
    bus_a.pattern_in = 8'h01;
    repeat (4) @(negedge clk_50M);
    wait_tick(1'b0, "midfade rise tick");
    bus_a.pattern_in = 8'h00;
    measure(1'b0);
    check("old target at tick edge", hi[0], 255);
    wait_tick(1'b0, "midfade tick 191");
    wait_tick(1'b0, "midfade tick 127");
    repeat (11) @(negedge clk_50M);
    check("midfade lit before reset", bus_a.led_out[0], 1'b1);
    reset = 1'b1;
    @(negedge clk_50M);
    check("midfade led_out after reset", bus_a.led_out, 8'h00);
    check("midfade fade_tick after reset", bus_a.fade_tick, 1'b0);
    reset = 1'b0;
    first_tick("midfade first tick");
    measure(1'b0);
    check("midfade restart level", hi[0], 0);

    // Saturation on the RISE_STEP=100 instance.
    reset = 1'b1;
    repeat (2) @(negedge clk_50M);
    reset = 1'b0;
    bus_s.pattern_in = 8'h01;
    repeat (4) @(negedge clk_50M);
    for (int k = 0; k < 4; k++) begin
      wait_tick(1'b1, $sformatf("sat tick%0d", k));
      measure(1'b1);
      check($sformatf("sat step%0d led0", k), hi[0], sat_exp[k]);
      check($sformatf("sat step%0d led1", k), hi[1], 0);
    end

    // Random patterns, glitches and resets against the model.
    reset = 1'b1;
    repeat (2) @(negedge clk_50M);
    cmp_en = 1'b1;
    begin
      int cyc = 0;
      int hold;
      while (cyc < 12000) begin
        if ($urandom_range(0, 24) == 0) begin
          reset = 1'b1;
          hold = $urandom_range(1, 3);
        end else begin
          reset = 1'b0;
          case ($urandom_range(0, 3))
            0:       hold = 1;
            1:       hold = $urandom_range(2, 5);
            default: hold = $urandom_range(300, 1500);
          endcase
          bus_a.pattern_in = 8'($urandom);
        end
        repeat (hold) @(negedge clk_50M);
        cyc += hold;
      end
    end
    cmp_en = 1'b0;
    reset  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Downstream stage for the LED pattern generator: takes the 8-bit LED pattern produced on the divided clock and drives the physical LEDs with per-LED PWM brightness. A lit bit drives its LED up toward full brightness, and a cleared bit fades it out over a programmable time, which gives a trailing "comet" effect. It sits between the pattern generator output and the board pins, and runs on the raw board clock.

## Interface
- FADE_PERIODS, 196: PWM periods per fade step (196 × 255 cycles ≈ 1 ms at 50 MHz); legal range 1..1023
- RISE_STEP, 255: level increment per fade step while the target bit is 1; legal range 1..255
- FALL_STEP, 8: level decrement per fade step while the target bit is 0; legal range 1..255
- clk_50M  input  1  board clock; the only clock in the block
- reset  input  1  synchronous, active-high reset
- pattern_in  input  8  LED pattern from the upstream generator; asynchronous to clk_50M (divided-clock domain)
- led_out  output  8  PWM-modulated LED drive, registered
- fade_tick  output  1  one-cycle pulse on the cycle in which the level registers update

## Operation
- Input capture:
  - 3-flop chain sync1→sync2→sync3 on pattern_in.
  - target ← sync2 only when sync2 == sync3, which gives two-sample stability and rejects multi-bit skew.
- PWM counter pwm_cnt counts 0..254 and wraps, so the period is 255 cycles.
- Period counter per_cnt advances on each pwm_cnt wrap and counts 0..FADE_PERIODS-1.
- Fade tick is asserted when pwm_cnt == 254 and per_cnt == FADE_PERIODS-1.
- Per LED i, level[i] is 8 bits. On the fade tick:
  - If target[i] = 1: level ← min(level + RISE_STEP, 255).
  - Otherwise: level ← max(level − FALL_STEP, 0).
  - Compute in 9 bits and saturate; never wrap.
- Output: led_out[i] ← (level[i] > pwm_cnt).
  - Level 0 is constantly off.
  - Level 255 is constantly on.
  - Level L is on for L cycles per period.
- Levels change only at a period boundary, so there are no partial-period glitches.
- Reset values:
  - sync1/2/3, target, level[*], pwm_cnt, per_cnt: 0.
  - led_out = 8'h00, fade_tick = 0.
- Reset mid-fade: all LEDs are dark on the cycle after reset is sampled. The fade restarts from level 0.

## Timing
- A pattern_in change sampled at edge k lands in target at edge k+3, provided it is held stable.
- A target change has effect at the next fade tick, which is up to 255 × FADE_PERIODS cycles later.
- Simultaneous target update and fade tick on the same edge: the fade uses the old target. The new target applies at the following tick.
- led_out lags pwm_cnt/level by 1 cycle (registered compare).
- fade_tick is high for exactly 1 cycle per 255 × FADE_PERIODS cycles, coincident with the level-register update edge.
- Full fade-out from 255 with FALL_STEP = 8 takes 32 ticks (last step 7 → 0). With default RISE_STEP, full rise takes 1 tick.
- A pattern_in glitch of 1 clk_50M cycle never reaches target.

## Structure
- Package led_pkg holds:
  - N_LED = 8, PWM_MAX = 254, LEVEL_MAX = 255.
  - The level_t (8-bit) typedef.
- Sub-module led_pwm_channel, instantiated N_LED times: one level register, the saturating up/down update, and the registered compare against the shared pwm_cnt.
- The top level holds the synchronizer, target register, pwm_cnt/per_cnt and fade_tick generation.
- The board top inserts this block between the pattern generator output and the LED pins.

## Test plan
Use FADE_PERIODS = 2, RISE_STEP = 255, FALL_STEP = 64 unless stated.
- Reset: assert reset for 3 cycles → led_out = 8'h00, fade_tick = 0. First fade_tick occurs 510 cycles after reset release.
- Rise: pattern_in = 8'h01 → target = 8'h01 within 4 edges. After the first tick, led_out[0] = 1 every cycle; other LEDs stay 0.
- Fade: pattern_in 8'h01 → 8'h00 after level = 255. Levels step 191, 127, 63, 0 on successive ticks, so led_out[0] high-time per period is 191, 127, 63, 0 cycles.
- Saturation: RISE_STEP = 100, target bit = 1 → levels 100, 200, 255, 255; no wrap to 44.
- Glitch/skew: a 1-cycle pulse on pattern_in = 8'hFF → target stays 8'h00 and led_out stays 0.
- Reset mid-fade: assert reset while level = 127 → led_out = 8'h00 on the next cycle. After release, fading resumes from 0.
